// File: rtl/inst_fetch_pkg.sv
// Shared constants and instruction definitions for the fetch stage: XLEN, boot address,
// NOP encoding, fetch FSM state encodings and the buffered {pc, inst} entry layout.
package inst_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] CPU_START_ADDR = 32'h8000_0000;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_REQ   = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO, head visible combinationally; push-to-head latency 1 cycle.
// No internal backpressure: the producer must not push when count==2; clear wins over push/pop.
module fetch_buf #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             clear,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head_dat
);

  logic [1:0][WIDTH-1:0] mem_q, mem_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding bus request into a 2-entry {pc, inst} buffer; decode sees a word 1 cycle after its response.
// Requests only when a buffer slot is free; pause holds the PC except in the cycle a request is accepted; id_stall holds the head.
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic            pause,
  input  logic            flush,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_resp_valid,
  input  logic [31:0]     mem_resp_data,
  input  logic            id_stall,
  output logic            id_valid,
  output logic [31:0]     id_inst,
  output logic [XLEN-1:0] id_pc
);

  fetch_state_e                 state_q, state_d;
  logic [XLEN-1:0]              req_pc_q, req_pc_d;
  logic [1:0]                   count;
  logic                         push;
  logic                         pop;
  fetch_entry_t                 push_entry;
  fetch_entry_t                 head;
  logic [FETCH_ENTRY_W-1:0]     head_dat;

  always_comb begin
    state_d       = state_q;
    req_pc_d      = req_pc_q;
    mem_req_valid = 1'b0;
    pause         = 1'b1;
    push          = 1'b0;
    case (state_q)
      FETCH_REQ: begin
        // Space is reserved before issuing, so a response can always be pushed.
        mem_req_valid = rst && (count != 2'd2);
        if (mem_req_valid && mem_req_ready) begin
          pause    = 1'b0;
          req_pc_d = pc_in;
          state_d  = flush ? FETCH_DRAIN : FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (mem_resp_valid) begin
          push    = !flush;
          state_d = FETCH_REQ;
        end else if (flush) begin
          state_d = FETCH_DRAIN;
        end
      end
      FETCH_DRAIN: begin
        // The stale response retires the only outstanding request, even under a repeated flush.
        if (mem_resp_valid) begin
          state_d = FETCH_REQ;
        end
      end
      default: state_d = FETCH_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= FETCH_REQ;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  assign mem_req_addr    = pc_in;
  assign push_entry.pc   = req_pc_q;
  assign push_entry.inst = mem_resp_data;
  assign pop             = id_valid && !id_stall && !flush;

  fetch_buf #(
    .WIDTH(FETCH_ENTRY_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_dat(push_entry),
    .pop     (pop),
    .clear   (flush),
    .count   (count),
    .head_dat(head_dat)
  );

  assign head     = fetch_entry_t'(head_dat);
  assign id_valid = (count != 2'd0);
  assign id_inst  = id_valid ? head.inst : INST_NOP;
  assign id_pc    = id_valid ? head.pc : '0;

endmodule

// File: tb/tb_inst_fetch.sv
// Scenario bench for inst_fetch: tasks drive the bus/decode side cycle by cycle, a scoreboard
// queue holds the {pc, inst} words decode must see, in order.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] pc_in;
  logic            pause;
  logic            flush;
  logic            mem_req_valid;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_req_ready;
  logic            mem_resp_valid;
  logic [31:0]     mem_resp_data;
  logic            id_stall;
  logic            id_valid;
  logic [31:0]     id_inst;
  logic [XLEN-1:0] id_pc;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0]     exp_q[$];
  logic [63:0]     sb_tmp;
  logic            acc_q = 1'b0;
  logic [XLEN-1:0] req_pc_tb = '0;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .pc_in         (pc_in),
    .pause         (pause),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .id_stall      (id_stall),
    .id_valid      (id_valid),
    .id_inst       (id_inst),
    .id_pc         (id_pc)
  );

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0033;
  endfunction

  // Scoreboard: every valid head is compared against the oldest expected word.
  always @(negedge clk) begin
    if (id_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got pc=%h inst=%h, required no valid instruction", id_pc, id_inst);
      end else if ({id_pc, id_inst} !== exp_q[0]) begin
        n_err++;
        $display("FAIL sb_head: got pc=%h inst=%h, required pc=%h inst=%h",
                 id_pc, id_inst, exp_q[0][63:32], exp_q[0][31:0]);
      end
    end
    if (rst !== 1'b1 || flush === 1'b1) exp_q.delete();
    else if (id_valid === 1'b1 && id_stall === 1'b0 && exp_q.size() != 0) sb_tmp = exp_q.pop_front();
  end

  // Advance one clock; the PC model steps only when the DUT released pause.
  task automatic cyc();
    logic acc;
    acc = (pause === 1'b0);
    @(posedge clk);
    #1;
    acc_q = acc;
    if (acc) begin
      req_pc_tb = pc_in;
      pc_in     = pc_in + 32'd4;
    end
    mem_resp_valid = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic expect_push);
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    if (expect_push) exp_q.push_back({req_pc_tb, data});
  endtask

  task automatic test_reset();
    rst = 1'b0; pc_in = CPU_START_ADDR; flush = 1'b0; mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0; mem_resp_data = '0; id_stall = 1'b0;
    repeat (2) cyc();
    #1;
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid: got %b required 0", mem_req_valid); end
    n_cmp++; if (pause !== 1'b1) begin n_err++; $display("FAIL reset_pause: got %b required 1", pause); end
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_id_valid: got %b required 0", id_valid); end
    n_cmp++; if (id_inst !== 32'h0000_0013) begin n_err++; $display("FAIL reset_id_inst: got %h required 00000013", id_inst); end
    n_cmp++; if (id_pc !== '0) begin n_err++; $display("FAIL reset_id_pc: got %h required 0", id_pc); end
    rst = 1'b1; mem_req_ready = 1'b0;
    #1;
    n_cmp++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL post_reset_req_valid: got %b required 1", mem_req_valid); end
    n_cmp++; if (pause !== 1'b1) begin n_err++; $display("FAIL post_reset_pause: got %b required 1", pause); end
    cyc();
  endtask

  task automatic test_stream();
    int n_pop;
    n_pop = 0;
    pc_in = CPU_START_ADDR; mem_req_ready = 1'b1; id_stall = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (acc_q) respond(mk_inst(req_pc_tb), 1'b1);
      #1;
      n_cmp++; if (pause !== ((i % 2) != 0)) begin n_err++; $display("FAIL stream_pause[%0d]: got %b required %b", i, pause, (i % 2) != 0); end
      n_cmp++; if (id_valid !== (i >= 2 && (i % 2) == 0)) begin n_err++; $display("FAIL stream_id_valid[%0d]: got %b required %b", i, id_valid, (i >= 2 && (i % 2) == 0)); end
      if (id_valid === 1'b1 && n_pop < 3) begin
        n_cmp++; if (id_pc !== CPU_START_ADDR + 32'(4 * n_pop)) begin n_err++; $display("FAIL stream_id_pc[%0d]: got %h required %h", n_pop, id_pc, CPU_START_ADDR + 32'(4 * n_pop)); end
        n_pop++;
      end
      cyc();
    end
    mem_req_ready = 1'b0;
    #1; cyc();
    #1;
    n_cmp++; if (id_valid !== 1'b0 || exp_q.size() != 0) begin n_err++; $display("FAIL stream_drain: got id_valid=%b pending=%0d required 0/0", id_valid, exp_q.size()); end
  endtask

  task automatic test_stall();
    logic [XLEN-1:0] p0;
    p0 = pc_in; id_stall = 1'b1; mem_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (acc_q) respond(mk_inst(req_pc_tb), 1'b1);
      #1;
      if (i >= 4) begin
        n_cmp++; if (mem_req_valid !== 1'b0 || pause !== 1'b1) begin n_err++; $display("FAIL stall_full_req[%0d]: got valid=%b pause=%b required 0/1", i, mem_req_valid, pause); end
        n_cmp++; if (dut.count !== 2'd2 || id_pc !== p0) begin n_err++; $display("FAIL stall_full_head[%0d]: got count=%0d pc=%h required 2/%h", i, dut.count, id_pc, p0); end
        n_cmp++; if (pc_in !== p0 + 32'd8) begin n_err++; $display("FAIL stall_pc_held[%0d]: got %h required %h", i, pc_in, p0 + 32'd8); end
      end
      cyc();
    end
    id_stall = 1'b0; mem_req_ready = 1'b0;
    #1; cyc();
    #1;
    n_cmp++; if (id_pc !== p0 + 32'd4) begin n_err++; $display("FAIL stall_order: got %h required %h", id_pc, p0 + 32'd4); end
    cyc();
    #1;
    n_cmp++; if (id_valid !== 1'b0 || exp_q.size() != 0) begin n_err++; $display("FAIL stall_drain: got id_valid=%b pending=%0d required 0/0", id_valid, exp_q.size()); end
  endtask

  task automatic test_flush_wait();
    mem_req_ready = 1'b1;
    #1;
    n_cmp++; if (pause !== 1'b0) begin n_err++; $display("FAIL flush_accept: got pause=%b required 0", pause); end
    cyc();
    flush = 1'b1;
    #1;
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL flush_wait_req: got %b required 0", mem_req_valid); end
    cyc();
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if (dut.state_q !== FETCH_DRAIN || mem_req_valid !== 1'b0 || id_valid !== 1'b0) begin n_err++; $display("FAIL flush_drain[%0d]: got state=%0d valid=%b id_valid=%b required DRAIN/0/0", i, dut.state_q, mem_req_valid, id_valid); end
      cyc();
    end
    respond(32'hDEAD_BEEF, 1'b0);
    #1;
    n_cmp++; if (dut.state_q !== FETCH_DRAIN || mem_req_valid !== 1'b0) begin n_err++; $display("FAIL flush_discard: got state=%0d valid=%b required DRAIN/0", dut.state_q, mem_req_valid); end
    cyc();
    #1;
    n_cmp++; if (mem_req_valid !== 1'b1 || pause !== 1'b0 || id_valid !== 1'b0) begin n_err++; $display("FAIL flush_reissue: got valid=%b pause=%b id_valid=%b required 1/0/0", mem_req_valid, pause, id_valid); end
    cyc();
    respond(mk_inst(req_pc_tb), 1'b1); mem_req_ready = 1'b0;
    #1; cyc();
    #1;
    n_cmp++; if (id_valid !== 1'b1 || id_inst !== mk_inst(req_pc_tb)) begin n_err++; $display("FAIL flush_next_word: got valid=%b inst=%h required 1/%h", id_valid, id_inst, mk_inst(req_pc_tb)); end
    cyc();
    #1;
    n_cmp++; if (id_valid !== 1'b0 || exp_q.size() != 0) begin n_err++; $display("FAIL flush_drain_end: got id_valid=%b pending=%0d required 0/0", id_valid, exp_q.size()); end
  endtask

  task automatic test_push_pop();
    logic [XLEN-1:0] a_pc, b_pc;
    id_stall = 1'b1; mem_req_ready = 1'b1;
    #1;
    n_cmp++; if (pause !== 1'b0) begin n_err++; $display("FAIL pp_accept_a: got pause=%b required 0", pause); end
    cyc(); a_pc = req_pc_tb;
    respond(mk_inst(a_pc), 1'b1);
    #1; cyc();
    #1;
    n_cmp++; if (id_valid !== 1'b1 || pause !== 1'b0) begin n_err++; $display("FAIL pp_accept_b: got id_valid=%b pause=%b required 1/0", id_valid, pause); end
    cyc(); b_pc = req_pc_tb;
    respond(mk_inst(b_pc), 1'b1); id_stall = 1'b0; mem_req_ready = 1'b0;
    #1;
    n_cmp++; if (dut.count !== 2'd1 || id_pc !== a_pc) begin n_err++; $display("FAIL pp_before: got count=%0d pc=%h required 1/%h", dut.count, id_pc, a_pc); end
    cyc();
    #1;
    n_cmp++; if (dut.count !== 2'd1 || id_pc !== b_pc || id_inst !== mk_inst(b_pc)) begin n_err++; $display("FAIL pp_after: got count=%0d pc=%h inst=%h required 1/%h/%h", dut.count, id_pc, id_inst, b_pc, mk_inst(b_pc)); end
    cyc();
    #1;
    n_cmp++; if (id_valid !== 1'b0 || exp_q.size() != 0) begin n_err++; $display("FAIL pp_drain: got id_valid=%b pending=%0d required 0/0", id_valid, exp_q.size()); end
  endtask

  task automatic test_ready_low();
    logic [XLEN-1:0] p0;
    p0 = pc_in; mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (mem_req_valid !== 1'b1 || pause !== 1'b1 || pc_in !== p0) begin n_err++; $display("FAIL rdy_low[%0d]: got valid=%b pause=%b pc=%h required 1/1/%h", i, mem_req_valid, pause, pc_in, p0); end
      cyc();
    end
    mem_req_ready = 1'b1;
    #1;
    n_cmp++; if (pause !== 1'b0 || mem_req_addr !== p0) begin n_err++; $display("FAIL rdy_accept: got pause=%b addr=%h required 0/%h", pause, mem_req_addr, p0); end
    cyc();
    mem_req_ready = 1'b0; respond(mk_inst(req_pc_tb), 1'b1);
    #1;
    n_cmp++; if (pause !== 1'b1) begin n_err++; $display("FAIL rdy_pause_one: got %b required 1", pause); end
    cyc();
    #1;
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== p0) begin n_err++; $display("FAIL rdy_word: got valid=%b pc=%h required 1/%h", id_valid, id_pc, p0); end
    cyc();
    #1;
    n_cmp++; if (id_valid !== 1'b0 || exp_q.size() != 0) begin n_err++; $display("FAIL rdy_drain: got id_valid=%b pending=%0d required 0/0", id_valid, exp_q.size()); end
  endtask

  task automatic test_reset_mid_wait();
    mem_req_ready = 1'b1;
    #1; cyc();
    rst = 1'b0; mem_req_ready = 1'b0; respond(32'hDEAD_BEEF, 1'b0);
    #1;
    n_cmp++; if (mem_req_valid !== 1'b0 || pause !== 1'b1) begin n_err++; $display("FAIL rmw_in_reset: got valid=%b pause=%b required 0/1", mem_req_valid, pause); end
    cyc();
    rst = 1'b1;
    #1;
    n_cmp++; if (dut.state_q !== FETCH_REQ || mem_req_valid !== 1'b1) begin n_err++; $display("FAIL rmw_state: got state=%0d valid=%b required REQ/1", dut.state_q, mem_req_valid); end
    n_cmp++; if (id_valid !== 1'b0 || id_inst !== 32'h0000_0013 || id_pc !== '0) begin n_err++; $display("FAIL rmw_outputs: got valid=%b inst=%h pc=%h required 0/00000013/0", id_valid, id_inst, id_pc); end
    cyc();
    mem_req_ready = 1'b1;
    #1;
    n_cmp++; if (id_valid !== 1'b0 || pause !== 1'b0) begin n_err++; $display("FAIL rmw_resume: got id_valid=%b pause=%b required 0/0", id_valid, pause); end
    cyc();
    respond(mk_inst(req_pc_tb), 1'b1); mem_req_ready = 1'b0;
    #1; cyc();
    #1;
    n_cmp++; if (id_valid !== 1'b1 || id_pc !== req_pc_tb) begin n_err++; $display("FAIL rmw_word: got valid=%b pc=%h required 1/%h", id_valid, id_pc, req_pc_tb); end
    cyc();
    #1;
    n_cmp++; if (id_valid !== 1'b0 || exp_q.size() != 0) begin n_err++; $display("FAIL rmw_drain: got id_valid=%b pending=%0d required 0/0", id_valid, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush_wait();
    test_push_pop();
    test_ready_low();
    test_reset_mid_wait();
    #20;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test by 100000 time units, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
